gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
- Self-test sequencer for any 2-input combinational gate (NAND by default) built in this codebase.
- Sits directly upstream and downstream of the gate under test: drives its a/b inputs through all four input combinations and consumes its c output.
- Compares each sampled c against a parameterised truth table, then reports pass/fail, a per-vector failure mask and a saturating error count.
- Lets gate models (dataflow, behavioural, structural) be checked in hardware or simulation without a hand-written stimulus block.

Parameters:
- TRUTH_TABLE, 4'b0111, expected c indexed by {a,b}; bit[{a,b}] is the expected output (4'b0111 = NAND).
- SETTLE_CYCLES, 2, cycles the vector is held before sampling; legal range 1..15.
- LOOPS, 1, number of complete 4-vector sweeps per run; legal range 1..255.
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled in IDLE only.
- c_dut  input  1  output of the gate under test.
- a  output  1  gate input A, registered.
- b  output  1  gate input B, registered.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 if the last completed run had zero mismatches.
- fail_vec  output  4  bit i set if vector {a,b}=i mismatched in any loop of the last run.
- err_count  output  ERR_CNT_W  total mismatches in the last run, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a=0, b=0, busy=0, done=0, pass=0.
  - fail_vec=0, err_count=0.
  - FSM=IDLE; vector index and loop counter cleared.
- Reset mid-run aborts immediately with the same values; no done pulse is produced.
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On an edge with start=1: {a,b}<=2'b00, busy<=1, fail_vec<=0, err_count<=0, pass<=0.
  - Settle counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: counter decrements each cycle; when it is 0, go to SAMPLE.
  - The vector is therefore held for exactly SETTLE_CYCLES cycles before the sample cycle.
- SAMPLE (one cycle): compare c_dut against TRUTH_TABLE[{a,b}] on the exiting edge.
  - On mismatch: fail_vec[{a,b}]<=1 and err_count<=err_count+1, except hold at all-ones (saturate).
  - Simulation: c_dut of X or Z counts as a mismatch (case-inequality compare).
  - If the vector is not 3: {a,b}<={a,b}+1, reload the settle counter, go to SETTLE.
  - If the vector is 3 and the loop count < LOOPS-1: {a,b}<=0, increment the loop count, go to SETTLE.
  - If the vector is 3 and this is the last loop: go to DONE, busy<=0, done<=1, a/b hold at 1/1.
  - pass<=1 if no mismatch occurred in the whole run, including this sample.
- DONE (one cycle): done<=0, go to IDLE.
  - pass, fail_vec and err_count hold until the next accepted start.
- Latency: a vector is sampled every SETTLE_CYCLES+1 cycles.
  - With the start edge as E0, the final sample edge is E(4*LOOPS*(SETTLE_CYCLES+1)).
  - done is high for the cycle after that edge.
- start is ignored while busy=1 and during DONE; no queuing.
- A start held high continuously restarts a run on the first IDLE edge after DONE.
- All outputs are registered; there is no combinational path from c_dut to any output.

Test Plan:
- NAND model attached, defaults, start pulse at E0:
  - a,b step 00,01,10,11 at E0,E3,E6,E9.
  - done=1 after E12, pass=1, fail_vec=0000, err_count=0.
- c_dut tied to 1, defaults:
  - pass=0, fail_vec=4'b1000, err_count=1.
- AND model attached (inverted), LOOPS=3:
  - fail_vec=4'b1111, err_count=12, done after E36.
- AND model, ERR_CNT_W=2, LOOPS=2:
  - err_count saturates at 3, fail_vec=4'b1111, pass=0.
- start re-pulsed at E5 of a run:
  - ignored; single done after E12 with results identical to the first scenario.
- rst_n low at E7, released at E9, start at E11:
  - outputs cleared at E7 and no done from the aborted run.
  - New run completes cleanly after E23 with pass=1.

Source files
------------

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives a 2-input gate through all four {a,b} vectors,
// holds each vector for SETTLE_CYCLES before sampling c_dut, and compares the
// sample against TRUTH_TABLE. The result of the last run is reported as pass,
// a per-vector failure mask and a saturating mismatch count.
module gate_truth_checker #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 1,
  parameter int         ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 c_dut,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           fail_vec,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]           LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

  // Expected gate output for vector {a,b}.
  function automatic logic expected_c(input logic [1:0] vec);
    return TRUTH_TABLE[vec];
  endfunction

  state_t                 state_r,     state_next_s;
  logic [1:0]             vec_r,       vec_next_s;
  logic [3:0]             settle_r,    settle_next_s;
  logic [7:0]             loop_r,      loop_next_s;
  logic                   busy_r,      busy_next_s;
  logic                   done_r,      done_next_s;
  logic                   pass_r,      pass_next_s;
  logic [3:0]             fail_vec_r,  fail_vec_next_s;
  logic [ERR_CNT_W-1:0]   err_cnt_r,   err_cnt_next_s;
  logic                   mismatch_s;

  // State and result registers; reset aborts a run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      vec_r      <= 2'b00;
      settle_r   <= 4'd0;
      loop_r     <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_vec_r <= 4'b0000;
      err_cnt_r  <= '0;
    end else begin
      state_r    <= state_next_s;
      vec_r      <= vec_next_s;
      settle_r   <= settle_next_s;
      loop_r     <= loop_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      pass_r     <= pass_next_s;
      fail_vec_r <= fail_vec_next_s;
      err_cnt_r  <= err_cnt_next_s;
    end
  end

  // Sequencer: next state, vector stepping and result accumulation.
  always_comb begin
    state_next_s    = state_r;
    vec_next_s      = vec_r;
    settle_next_s   = settle_r;
    loop_next_s     = loop_r;
    busy_next_s     = busy_r;
    done_next_s     = done_r;
    pass_next_s     = pass_r;
    fail_vec_next_s = fail_vec_r;
    err_cnt_next_s  = err_cnt_r;
    mismatch_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          vec_next_s      = 2'b00;
          settle_next_s   = SETTLE_LOAD;
          loop_next_s     = 8'd0;
          busy_next_s     = 1'b1;
          pass_next_s     = 1'b0;
          fail_vec_next_s = 4'b0000;
          err_cnt_next_s  = '0;
          state_next_s    = ST_SETTLE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (settle_r == 4'd0) begin
          state_next_s = ST_SAMPLE;
        end else begin
          settle_next_s = settle_r - 4'd1;
        end
      end

      ST_SAMPLE: begin
        // Case inequality so an X/Z from a simulated gate is a failure.
        mismatch_s = (c_dut !== expected_c(vec_r));
        if (mismatch_s) begin
          fail_vec_next_s[vec_r] = 1'b1;
          if (err_cnt_r != ERR_MAX) begin
            err_cnt_next_s = err_cnt_r + ERR_CNT_W'(1);
          end else begin
            err_cnt_next_s = err_cnt_r;
          end
        end else begin
          fail_vec_next_s = fail_vec_r;
        end

        if (vec_r != 2'b11) begin
          vec_next_s    = vec_r + 2'b01;
          settle_next_s = SETTLE_LOAD;
          state_next_s  = ST_SETTLE;
        end else if (loop_r != LOOP_LAST) begin
          vec_next_s    = 2'b00;
          loop_next_s   = loop_r + 8'd1;
          settle_next_s = SETTLE_LOAD;
          state_next_s  = ST_SETTLE;
        end else begin
          // a/b stay at 1/1 until the next run starts.
          busy_next_s  = 1'b0;
          done_next_s  = 1'b1;
          pass_next_s  = (fail_vec_r == 4'b0000) && !mismatch_s;
          state_next_s = ST_DONE;
        end
      end

      ST_DONE: begin
        done_next_s  = 1'b0;
        state_next_s = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign a         = vec_r[1];
  assign b         = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_vec  = fail_vec_r;
  assign err_count = err_cnt_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: three instances (defaults, LOOPS=3,
// ERR_CNT_W=2/LOOPS=2) each with a behavioural gate model on c_dut.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_req = 1'b0;
  int   sel = 0;
  int   mode = 0;   // main-instance gate model: 0 NAND, 1 tied 1, 2 tied 0

  always #5 clk = ~clk;

  logic       a0, b0, busy0, done0, pass0, c0;
  logic [3:0] fv0;
  logic [7:0] ec0;
  logic       a1, b1, busy1, done1, pass1, c1;
  logic [3:0] fv1;
  logic [7:0] ec1;
  logic       a2, b2, busy2, done2, pass2, c2;
  logic [3:0] fv2;
  logic [1:0] ec2;

  assign c0 = (mode == 0) ? ~(a0 & b0) : (mode == 1) ? 1'b1 : 1'b0;
  assign c1 = a1 & b1;
  assign c2 = a2 & b2;

  gate_truth_checker u_main (
    .clk(clk), .rst_n(rst_n), .start(start_req && (sel == 0)), .c_dut(c0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_vec(fv0), .err_count(ec0)
  );

  gate_truth_checker #(.LOOPS(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start_req && (sel == 1)), .c_dut(c1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fv1), .err_count(ec1)
  );

  gate_truth_checker #(.LOOPS(2), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_req && (sel == 2)), .c_dut(c2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_vec(fv2), .err_count(ec2)
  );

  logic [1:0] cur_ab;
  logic       cur_busy, cur_done, cur_pass;
  logic [3:0] cur_fv;
  logic [7:0] cur_ec;

  always_comb begin
    case (sel)
      1: begin
        cur_ab = {a1, b1}; cur_busy = busy1; cur_done = done1;
        cur_pass = pass1; cur_fv = fv1; cur_ec = ec1;
      end
      2: begin
        cur_ab = {a2, b2}; cur_busy = busy2; cur_done = done2;
        cur_pass = pass2; cur_fv = fv2; cur_ec = {6'd0, ec2};
      end
      default: begin
        cur_ab = {a0, b0}; cur_busy = busy0; cur_done = done0;
        cur_pass = pass0; cur_fv = fv0; cur_ec = ec0;
      end
    endcase
  end

  typedef struct {
    logic       pass;
    logic [3:0] fv;
    logic [7:0] ec;
    int         edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Launch one run at the next edge (E0), track a/b/busy every edge and
  // score the done pulse against the entry pushed at launch.
  task automatic run(input int sel_i, input int loops, input logic e_pass,
                     input logic [3:0] e_fv, input logic [7:0] e_ec, input int repulse_at);
    exp_t e;
    exp_t got_e;
    int final_e;
    int done_cnt;
    final_e = 4 * loops * 3;
    e.pass = e_pass; e.fv = e_fv; e.ec = e_ec; e.edge_n = final_e;
    sb.push_back(e);
    done_cnt = 0;
    sel = sel_i;
    start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
    check("ab_e0", 32'(cur_ab), 32'd0);
    check("busy_e0", 32'(cur_busy), 32'd1);
    for (int k = 1; k <= final_e + 5; k++) begin
      @(posedge clk);
      #1 start_req = 1'b0;
      if (k < final_e) begin
        check("ab_step", 32'(cur_ab), 32'((k / 3) % 4));
        check("busy_run", 32'(cur_busy), 32'd1);
      end else if (k == final_e) begin
        check("ab_end", 32'(cur_ab), 32'd3);
        check("busy_end", 32'(cur_busy), 32'd0);
      end else begin
        check("busy_idle", 32'(cur_busy), 32'd0);
      end
      if (cur_done) begin
        done_cnt++;
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          check("done_edge", 32'(k), 32'(got_e.edge_n));
          check("pass", 32'(cur_pass), 32'(got_e.pass));
          check("fail_vec", 32'(cur_fv), 32'(got_e.fv));
          check("err_count", 32'(cur_ec), 32'(got_e.ec));
        end
      end
      if (k == repulse_at - 1) start_req = 1'b1;
    end
    check("done_count", 32'(done_cnt), 32'd1);
    sb.delete();
  endtask

  initial begin
    sel = 0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", 32'(a0), 32'd0);
    check("rst_b", 32'(b0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_fv", 32'(fv0), 32'd0);
    check("rst_ec", 32'(ec0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // NAND model, defaults
    mode = 0;
    run(0, 1, 1'b1, 4'b0000, 8'd0, -1);
    check("hold_pass", 32'(pass0), 32'd1);
    // c_dut tied to 1
    mode = 1;
    run(0, 1, 1'b0, 4'b1000, 8'd1, -1);
    // AND model, LOOPS=3
    run(1, 3, 1'b0, 4'b1111, 8'd12, -1);
    // AND model, ERR_CNT_W=2 saturation
    run(2, 2, 1'b0, 4'b1111, 8'd3, -1);
    // start re-pulsed at E5 is ignored
    mode = 0;
    run(0, 1, 1'b1, 4'b0000, 8'd0, 5);

    // Reset mid-run: c_dut tied 0 so results are non-zero before reset.
    mode = 2;
    sel = 0;
    start_req = 1'b1;
    @(posedge clk);                    // E0
    #1 start_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) begin
        check("pre_rst_ec", 32'(ec0), 32'd2);
        check("pre_rst_fv", 32'(fv0), 32'b0011);
        rst_n = 1'b0;                  // asserted ahead of E7
        #1;
        check("rst_mid_busy", 32'(busy0), 32'd0);
        check("rst_mid_ab", 32'({a0, b0}), 32'd0);
        check("rst_mid_fv", 32'(fv0), 32'd0);
        check("rst_mid_ec", 32'(ec0), 32'd0);
      end
      if (k == 8) rst_n = 1'b1;        // released ahead of E9
      if (k >= 7) check("no_abort_done", 32'(done0), 32'd0);
    end
    mode = 0;
    run(0, 1, 1'b1, 4'b0000, 8'd0, -1);   // starts at E11, done after E23

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
